// File: rtl/nbit_mac_pkg.sv
// Shared constants for the sequential shift-add MAC: FSM encoding, default
// sizing and the derived accumulator / counter widths.
package nbit_mac_pkg;

  localparam int NBIT_DEF      = 12;
  localparam int ACC_GUARD_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic int acc_width(input int nbit, input int guard);
    return 2 * nbit + guard;
  endfunction

  // Counter must be able to hold the value NBIT itself, not just NBIT-1.
  function automatic int cnt_width(input int nbit);
    return $clog2(nbit + 1);
  endfunction

endpackage

// File: rtl/nbit_shift_add_core.sv
// Unsigned LSB-first shift-add multiplier datapath: one NBIT-wide adder
// feeding a 2*NBIT partial-product register that shifts right each step.
module nbit_shift_add_core
  import nbit_mac_pkg::*;
#(
  parameter int NBIT = NBIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [NBIT-1:0]   mcand,
  input  logic [NBIT-1:0]   mplier,
  output logic [2*NBIT-1:0] product
);

  logic [2*NBIT-1:0] pp_r;
  logic [NBIT:0]     sum_s;

  // Conditional add of the multiplicand into the upper half, keeping the carry.
  always_comb begin
    sum_s = {1'b0, pp_r[2*NBIT-1:NBIT]};
    if (pp_r[0]) begin
      sum_s = {1'b0, pp_r[2*NBIT-1:NBIT]} + {1'b0, mcand};
    end else begin
      sum_s = {1'b0, pp_r[2*NBIT-1:NBIT]};
    end
  end

  // Multiplier sits in the low half and is consumed as the product shifts in.
  always_ff @(posedge clk) begin
    if (rst) begin
      pp_r <= '0;
    end else if (load) begin
      pp_r <= {{NBIT{1'b0}}, mplier};
    end else if (step) begin
      pp_r <= {sum_s, pp_r[NBIT-1:1]};
    end else begin
      pp_r <= pp_r;
    end
  end

  assign product = pp_r;

endmodule

// File: rtl/nbit_seq_mac.sv
// Sequential multiply-accumulate: FSM, signed/unsigned magnitude handling,
// guarded two's-complement accumulator with sticky overflow and handshakes.
module nbit_seq_mac
  import nbit_mac_pkg::*;
#(
  parameter int NBIT      = NBIT_DEF,
  parameter int ACC_GUARD = ACC_GUARD_DEF,
  localparam int ACCW     = acc_width(NBIT, ACC_GUARD),
  localparam int CNTW     = cnt_width(NBIT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NBIT-1:0]   in1,
  input  logic [NBIT-1:0]   in2,
  input  logic              in_signed,
  input  logic              in_acc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NBIT-1:0] out_product,
  output logic [ACCW-1:0]   out_acc,
  output logic              out_ovf
);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [CNTW-1:0]   cnt_r;
  logic [NBIT-1:0]   mcand_r;
  logic              sign_r;
  logic              signed_r;
  logic              acc_op_r;
  logic              out_valid_r;
  logic [2*NBIT-1:0] out_product_r;
  logic [ACCW-1:0]   out_acc_r;
  logic              out_ovf_r;

  logic              accept_s;
  logic              step_s;
  logic [NBIT-1:0]   mag1_s;
  logic [NBIT-1:0]   mag2_s;
  logic [2*NBIT-1:0] core_product_s;
  logic [2*NBIT-1:0] prod_s;
  logic [ACCW-1:0]   ext_s;
  logic [ACCW-1:0]   sum_s;
  logic              ovf_s;

  assign accept_s = (state_r == ST_IDLE) && in_valid;
  assign step_s   = (state_r == ST_BUSY) && (cnt_r != CNTW'(NBIT));
  assign in_ready = (state_r == ST_IDLE) && !rst;

  // Magnitudes at capture; -2^(NBIT-1) negates to itself, which is its
  // correct unsigned magnitude.
  always_comb begin
    mag1_s = in1;
    mag2_s = in2;
    if (in_signed && in1[NBIT-1]) begin
      mag1_s = NBIT'(0) - in1;
    end else begin
      mag1_s = in1;
    end
    if (in_signed && in2[NBIT-1]) begin
      mag2_s = NBIT'(0) - in2;
    end else begin
      mag2_s = in2;
    end
  end

  nbit_shift_add_core #(.NBIT(NBIT)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (accept_s),
    .step    (step_s),
    .mcand   (mcand_r),
    .mplier  (mag2_s),
    .product (core_product_s)
  );

  // Re-apply the sign, widen to the accumulator and form the overflow flag.
  always_comb begin
    prod_s = core_product_s;
    ext_s  = '0;
    if (sign_r) begin
      prod_s = (2*NBIT)'(0) - core_product_s;
    end else begin
      prod_s = core_product_s;
    end
    if (signed_r) begin
      ext_s = ACCW'($signed(prod_s));
    end else begin
      ext_s = ACCW'(prod_s);
    end
    sum_s = out_acc_r + ext_s;
    ovf_s = (out_acc_r[ACCW-1] == ext_s[ACCW-1]) &&
            (sum_s[ACCW-1] != out_acc_r[ACCW-1]);
  end

  // Next-state decode; BUSY spends one extra cycle seeing the counter at NBIT.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNTW'(NBIT)) begin
          state_nxt_s = ST_FINISH;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_FINISH: state_nxt_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, operand capture, iteration counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      mcand_r       <= '0;
      sign_r        <= 1'b0;
      signed_r      <= 1'b0;
      acc_op_r      <= 1'b0;
      out_valid_r   <= 1'b0;
      out_product_r <= '0;
      out_acc_r     <= '0;
      out_ovf_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        mcand_r  <= mag1_s;
        sign_r   <= in_signed & (in1[NBIT-1] ^ in2[NBIT-1]);
        signed_r <= in_signed;
        acc_op_r <= in_acc;
        cnt_r    <= '0;
      end else if (step_s) begin
        cnt_r <= cnt_r + CNTW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      case (state_r)
        ST_FINISH: begin
          out_product_r <= prod_s;
          out_valid_r   <= 1'b1;
          if (acc_op_r) begin
            out_acc_r <= sum_s;
            out_ovf_r <= out_ovf_r | ovf_s;
          end else begin
            out_acc_r <= ext_s;
            out_ovf_r <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          out_valid_r <= out_valid_r;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_r;
  assign out_product = out_product_r;
  assign out_acc     = out_acc_r;
  assign out_ovf     = out_ovf_r;

endmodule

// File: tb/tb_nbit_seq_mac.sv
// Directed bench: a default-width unit and a no-guard-bit unit share all
// inputs so every operation is also checked against the 24-bit accumulator.
module tb_nbit_seq_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        in_acc = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in1 = 12'd0;
  logic [11:0] in2 = 12'd0;

  logic        in_ready0, out_valid0, ovf0;
  logic [23:0] prod0;
  logic [31:0] acc0;
  logic        in_ready1, out_valid1, ovf1;
  logic [23:0] prod1;
  logic [23:0] acc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nbit_seq_mac dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in1(in1), .in2(in2), .in_signed(in_signed), .in_acc(in_acc),
    .out_valid(out_valid0), .out_ready(out_ready), .out_product(prod0),
    .out_acc(acc0), .out_ovf(ovf0)
  );

  nbit_seq_mac #(.NBIT(12), .ACC_GUARD(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in1(in1), .in2(in2), .in_signed(in_signed), .in_acc(in_acc),
    .out_valid(out_valid1), .out_ready(out_ready), .out_product(prod1),
    .out_acc(acc1), .out_ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 40 && out_valid0 !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                       input logic s, input logic ac, input logic [23:0] ep,
                       input logic [31:0] ea0, input logic eo0,
                       input logic [23:0] ea1, input logic eo1);
    int n;
    @(negedge clk);
    chk({tag, "/in_ready"}, in_ready0, 1);
    in1 = a; in2 = b; in_signed = s; in_acc = ac; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = 12'hA5A; in2 = 12'h5A5; in_signed = ~s; in_acc = ~ac;
    wait_valid(n);
    chk({tag, "/latency"}, n, 14);
    chk({tag, "/prod0"}, prod0, ep);
    chk({tag, "/acc0"}, acc0, ea0);
    chk({tag, "/ovf0"}, ovf0, eo0);
    chk({tag, "/prod1"}, prod1, ep);
    chk({tag, "/acc1"}, acc1, ea1);
    chk({tag, "/ovf1"}, ovf1, eo1);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "/valid_drop"}, out_valid0, 0);
    chk({tag, "/idle_ready"}, in_ready0, 1);
  endtask

  initial begin
    int n;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst/valid", out_valid0, 0);
    chk("rst/prod", prod0, 0);
    chk("rst/acc", acc0, 0);
    chk("rst/ovf", ovf0, 0);
    chk("rst/in_ready", in_ready0, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst/release_ready", in_ready0, 1);

    // unsigned maximum and signed corners
    do_op("umax", 12'hFFF, 12'hFFF, 1'b0, 1'b0, 24'hFFE001, 32'h00FFE001, 1'b0, 24'hFFE001, 1'b0);
    do_op("smin2", 12'h800, 12'h800, 1'b1, 1'b0, 24'h400000, 32'h00400000, 1'b0, 24'h400000, 1'b0);
    do_op("sneg", 12'hFFF, 12'h005, 1'b1, 1'b0, 24'hFFFFFB, 32'hFFFFFFFB, 1'b0, 24'hFFFFFB, 1'b0);
    do_op("szero", 12'h000, 12'hFF9, 1'b1, 1'b0, 24'h000000, 32'h00000000, 1'b0, 24'h000000, 1'b0);

    // accumulate then reload
    do_op("ld3x4", 12'd3, 12'd4, 1'b0, 1'b0, 24'd12, 32'd12, 1'b0, 24'd12, 1'b0);
    do_op("acc5x6", 12'd5, 12'd6, 1'b0, 1'b1, 24'd30, 32'd42, 1'b0, 24'd42, 1'b0);
    do_op("ld2x2", 12'd2, 12'd2, 1'b0, 1'b0, 24'd4, 32'd4, 1'b0, 24'd4, 1'b0);

    // backpressure; in_valid held during BUSY with other operands
    @(negedge clk);
    in1 = 12'd7; in2 = 12'd3; in_signed = 1'b0; in_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in1 = 12'd100; in2 = 12'd100; in_acc = 1'b1;
    chk("bp/busy_ready", in_ready0, 0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp/valid_seen", out_valid0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp/hold_valid", out_valid0, 1);
      chk("bp/hold_prod", prod0, 21);
      chk("bp/hold_acc", acc0, 21);
      chk("bp/hold_ready", in_ready0, 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp/release_valid", out_valid0, 0);
    chk("bp/release_ready", in_ready0, 1);

    // out_ready raised early: DONE lasts a single cycle
    @(negedge clk);
    in1 = 12'd2; in2 = 12'd5; in_signed = 1'b0; in_acc = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_valid(n);
    chk("early/latency", n, 14);
    chk("early/prod", prod0, 10);
    chk("early/acc", acc0, 31);
    @(posedge clk); #1;
    chk("early/one_cycle", out_valid0, 0);
    out_ready = 1'b0;

    // overflow on the guard-less unit; default unit stays clean
    do_op("ovf_ld", 12'h7FF, 12'h7FF, 1'b1, 1'b0, 24'h3FF001, 32'h003FF001, 1'b0, 24'h3FF001, 1'b0);
    do_op("ovf_a1", 12'h7FF, 12'h7FF, 1'b1, 1'b1, 24'h3FF001, 32'h007FE002, 1'b0, 24'h7FE002, 1'b0);
    do_op("ovf_a2", 12'h7FF, 12'h7FF, 1'b1, 1'b1, 24'h3FF001, 32'h00BFD003, 1'b0, 24'hBFD003, 1'b1);
    do_op("ovf_a3", 12'h7FF, 12'h7FF, 1'b1, 1'b1, 24'h3FF001, 32'h00FFC004, 1'b0, 24'hFFC004, 1'b1);
    do_op("ovf_clr", 12'h7FF, 12'h7FF, 1'b1, 1'b0, 24'h3FF001, 32'h003FF001, 1'b0, 24'h3FF001, 1'b0);

    // reset during BUSY iteration 5
    @(negedge clk);
    in1 = 12'd11; in2 = 12'd13; in_signed = 1'b0; in_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst/valid", out_valid0, 0);
    chk("mid_rst/prod", prod0, 0);
    chk("mid_rst/acc0", acc0, 0);
    chk("mid_rst/acc1", acc1, 0);
    chk("mid_rst/ovf", ovf0, 0);
    chk("mid_rst/in_ready", in_ready0, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("mid_rst/release_ready", in_ready0, 1);
    do_op("post_rst", 12'd7, 12'd9, 1'b0, 1'b1, 24'd63, 32'd63, 1'b0, 24'd63, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
